// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I load/store funct3 codes, alignment/legality check, byte-lane
// enable and store-lane replication.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal = known funct3 for the direction and naturally aligned address.
    function automatic logic access_ok(input logic       is_write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        if (is_write) begin
            case (funct3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = ~offset[0];
                F3_W:    ok = (offset == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = ~offset[0];
                F3_W:        ok = (offset == 2'b00);
                default:     ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << {offset[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes; byte enables pick the live one.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Purpose: pick the addressed byte/halfword of a memory word and sign/zero extend it.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3 (load type), offset (addr[1:0]), raw (memory word), result (extended data).
module load_extender
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = raw[7:0];
        case (offset)
            2'd0:    lane_b = raw[7:0];
            2'd1:    lane_b = raw[15:8];
            2'd2:    lane_b = raw[23:16];
            default: lane_b = raw[31:24];
        endcase
        // Halfwords are aligned, so only addr[1] matters.
        lane_h = offset[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        result = raw;
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: one-at-a-time RV32I load/store access to word-organised data memory with alignment checking.
// Latency: accept->rsp_valid is 1 cycle (error), 2 (store), 2+MEM_LATENCY (load).
// Backpressure: req_ready only in IDLE; req_valid while busy is ignored, no response backpressure.
// Ports: clk/reset (async active-low); req_* request handshake and payload;
//        rsp_* one-cycle response; mem_* registered memory interface, mem_rdata raw read word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_wren,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byte_en,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    // Counter runs MEM_LATENCY-1 down to 0, so WAIT lasts MEM_LATENCY cycles.
    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

    lsu_state_t  state;
    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_offset;
    logic [1:0]  lat_cnt;
    logic [31:0] load_result;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    load_extender u_load_extender (
        .funct3 (lat_funct3),
        .offset (lat_offset),
        .raw    (mem_rdata),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lat_write   <= 1'b0;
            lat_funct3  <= 3'd0;
            lat_offset  <= 2'd0;
            lat_cnt     <= 2'd0;
            rsp_error   <= 1'b0;
            rsp_rdata   <= 32'd0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_byte_en <= 4'd0;
            mem_wdata   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (access_ok(req_write, req_funct3, req_addr[1:0])) begin
                            lat_write   <= req_write;
                            lat_funct3  <= req_funct3;
                            lat_offset  <= req_addr[1:0];
                            // Memory outputs are loaded on the accept edge so
                            // they are valid for the whole ISSUE cycle.
                            mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_byte_en <= byte_enable(req_funct3, req_addr[1:0]);
                            mem_wdata   <= store_lanes(req_funct3, req_wdata);
                            mem_wren    <= req_write;
                            state       <= S_ISSUE;
                        end else begin
                            // Illegal access never touches memory.
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    if (lat_write) begin
                        mem_wren    <= 1'b0;
                        mem_byte_en <= 4'd0;
                        rsp_error   <= 1'b0;
                        rsp_rdata   <= 32'd0;
                        state       <= S_RESP;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rsp_rdata   <= load_result;
                        rsp_error   <= 1'b0;
                        mem_byte_en <= 4'd0;
                        state       <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: self-checking bench for load_store_unit at MEM_LATENCY 1 and 3 against a byte-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid_a   [2];
    logic        req_ready_a   [2];
    logic        req_write_a   [2];
    logic [2:0]  req_funct3_a  [2];
    logic [31:0] req_addr_a    [2];
    logic [31:0] req_wdata_a   [2];
    logic        rsp_valid_a   [2];
    logic        rsp_error_a   [2];
    logic [31:0] rsp_rdata_a   [2];
    logic        mem_wren_a    [2];
    logic [31:0] mem_address_a [2];
    logic [3:0]  mem_byte_en_a [2];
    logic [31:0] mem_wdata_a   [2];
    logic [31:0] mem_rdata_a   [2];

    load_store_unit #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
        .req_funct3(req_funct3_a[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_error(rsp_error_a[0]), .rsp_rdata(rsp_rdata_a[0]),
        .mem_wren(mem_wren_a[0]), .mem_address(mem_address_a[0]), .mem_byte_en(mem_byte_en_a[0]),
        .mem_wdata(mem_wdata_a[0]), .mem_rdata(mem_rdata_a[0])
    );

    load_store_unit #(.MEM_LATENCY(3), .ADDR_WIDTH(32)) dut_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
        .req_funct3(req_funct3_a[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_error(rsp_error_a[1]), .rsp_rdata(rsp_rdata_a[1]),
        .mem_wren(mem_wren_a[1]), .mem_address(mem_address_a[1]), .mem_byte_en(mem_byte_en_a[1]),
        .mem_wdata(mem_wdata_a[1]), .mem_rdata(mem_rdata_a[1])
    );

    // Memory behind each DUT: byte-enabled writes, read data delayed
    // by that DUT's latency. Event counters for handshake checks.
    logic [31:0] dmem    [2][256];
    logic [31:0] ref_mem [2][256];
    logic [31:0] pipe    [2][3];
    int acc_cnt  [2] = '{0, 0};
    int wren_cnt [2] = '{0, 0};
    int rsp_cnt  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_wren_a[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byte_en_a[i][b])
                        dmem[i][mem_address_a[i][9:2]][8*b +: 8] <= mem_wdata_a[i][8*b +: 8];
                end
            end
            pipe[i][0] <= dmem[i][mem_address_a[i][9:2]];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
            if (reset && req_valid_a[i] && req_ready_a[i]) acc_cnt[i] <= acc_cnt[i] + 1;
            if (mem_wren_a[i]) wren_cnt[i] <= wren_cnt[i] + 1;
            if (rsp_valid_a[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
        end
    end

    assign mem_rdata_a[0] = pipe[0][0];
    assign mem_rdata_a[1] = pipe[1][2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input int d);
        check("rst_ready",   32'(req_ready_a[d]),   32'd1);
        check("rst_rsp_vld", 32'(rsp_valid_a[d]),   32'd0);
        check("rst_rsp_err", 32'(rsp_error_a[d]),   32'd0);
        check("rst_rdata",   rsp_rdata_a[d],        32'd0);
        check("rst_wren",    32'(mem_wren_a[d]),    32'd0);
        check("rst_addr",    mem_address_a[d],      32'd0);
        check("rst_be",      32'(mem_byte_en_a[d]), 32'd0);
        check("rst_wdata",   mem_wdata_a[d],        32'd0);
    endtask

    // One request on DUT d, with expectations computed from access size and
    // byte arithmetic on the reference memory.
    task automatic txn(input int d, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit hold, output logic [31:0] rd);
        int          size, lat, k, got_k, acc0, wr0;
        bit          legal;
        logic [3:0]  be_exp;
        logic [31:0] wd_exp, rd_exp, word, sh;

        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (legal && (addr % size) != 0) legal = 1'b0;

        be_exp = 4'(((1 << size) - 1) << (addr % 4));
        wd_exp = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;

        word = ref_mem[d][addr[9:2]];
        sh   = word >> (8 * (addr % 4));
        if (size == 1)      rd_exp = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (size == 2) rd_exp = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else                rd_exp = word;
        if (!legal || wr) rd_exp = 32'd0;

        lat = !legal ? 1 : wr ? 2 : 2 + ((d == 0) ? 1 : 3);

        @(negedge clk);
        check("ready_idle", 32'(req_ready_a[d]), 32'd1);
        req_write_a[d]  = wr;
        req_funct3_a[d] = f3;
        req_addr_a[d]   = addr;
        req_wdata_a[d]  = wd;
        req_valid_a[d]  = 1'b1;
        acc0 = acc_cnt[d];
        wr0  = wren_cnt[d];
        @(posedge clk);
        #1;
        if (!hold) req_valid_a[d] = 1'b0;
        // Inputs after the accept edge must not matter.
        req_write_a[d]  = 1'($urandom);
        req_funct3_a[d] = 3'($urandom);
        req_addr_a[d]   = $urandom;
        req_wdata_a[d]  = $urandom;

        got_k = 0;
        for (k = 1; k <= 20 && got_k == 0; k++) begin
            @(negedge clk);
            if (k == 1 && legal) begin
                check("issue_wren", 32'(mem_wren_a[d]),    32'(wr));
                check("issue_addr", mem_address_a[d],      {addr[31:2], 2'b00});
                check("issue_be",   32'(mem_byte_en_a[d]), 32'(be_exp));
                if (wr) check("issue_wdata", mem_wdata_a[d], wd_exp);
            end
            if (rsp_valid_a[d]) got_k = k;
        end
        req_valid_a[d] = 1'b0;

        check("rsp_latency", 32'(got_k),             32'(lat));
        check("rsp_error",   32'(rsp_error_a[d]),    32'(!legal));
        check("rsp_rdata",   rsp_rdata_a[d],         rd_exp);
        check("rsp_be_zero", 32'(mem_byte_en_a[d]),  32'd0);
        check("rsp_wren_lo", 32'(mem_wren_a[d]),     32'd0);
        check("accepts",     32'(acc_cnt[d] - acc0), 32'd1);
        check("wren_cycles", 32'(wren_cnt[d] - wr0), 32'(legal && wr));
        rd = rsp_rdata_a[d];

        if (legal && wr) begin
            for (int b = 0; b < 4; b++)
                if (be_exp[b]) ref_mem[d][addr[9:2]][8*b +: 8] = wd_exp[8*b +: 8];
        end
    endtask

    logic [31:0] rd;
    int          rsp0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 256; w++) begin
                dmem[i][w]    = $urandom;
                ref_mem[i][w] = dmem[i][w];
            end
            req_valid_a[i]  = 1'b0;
            req_write_a[i]  = 1'b0;
            req_funct3_a[i] = 3'd0;
            req_addr_a[i]   = 32'd0;
            req_wdata_a[i]  = 32'd0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        reset = 1'b1;

        // Directed stores and the load-extension table at MEM_LATENCY=1.
        txn(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, rd);
        txn(0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b0, rd);
        txn(0, 1'b1, 3'b010, 32'h200, 32'h80FF7F01, 1'b0, rd);
        txn(0, 1'b0, 3'b000, 32'h203, 32'h0, 1'b0, rd);
        check("lb_off3",  rd, 32'hFFFFFF80);
        txn(0, 1'b0, 3'b100, 32'h203, 32'h0, 1'b0, rd);
        check("lbu_off3", rd, 32'h00000080);
        txn(0, 1'b0, 3'b001, 32'h202, 32'h0, 1'b0, rd);
        check("lh_off2",  rd, 32'hFFFF80FF);
        txn(0, 1'b0, 3'b101, 32'h200, 32'h0, 1'b0, rd);
        check("lhu_off0", rd, 32'h00007F01);
        txn(0, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, rd);
        check("lw",       rd, 32'h80FF7F01);
        txn(0, 1'b0, 3'b010, 32'h102, 32'h0, 1'b0, rd);
        txn(0, 1'b1, 3'b001, 32'h101, 32'h1234, 1'b0, rd);

        // MEM_LATENCY=3 with req_valid held high through the access.
        txn(1, 1'b1, 3'b010, 32'h200, 32'h13572468, 1'b0, rd);
        txn(1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, rd);
        check("lw_l3", rd, 32'h13572468);

        // Reset in the middle of a load's WAIT phase.
        @(negedge clk);
        req_write_a[1]  = 1'b0;
        req_funct3_a[1] = 3'b010;
        req_addr_a[1]   = 32'h200;
        req_valid_a[1]  = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals(1);
        rsp0 = rsp_cnt[1];
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("no_rsp_after_rst", 32'(rsp_cnt[1] - rsp0), 32'd0);
        txn(1, 1'b0, 3'b100, 32'h201, 32'h0, 1'b0, rd);
        check("post_rst_lbu", rd, 32'h00000024);

        // Randomized mix on both latencies.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            txn(int'($urandom_range(0, 1)), 1'($urandom), 3'($urandom), a, $urandom,
                1'($urandom), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the multi-cycle core's control unit/datapath and the word-organised data memory. Accepts one load or store request at a time and checks RV32I alignment. Drives word-aligned address, byte enables and lane-replicated write data. Waits out the memory's read latency, then returns a sign- or zero-extended load result with a one-cycle response pulse.

## Interface
Parameters:
- MEM_LATENCY, 1, data-memory read latency in cycles (legal 1..3)
- ADDR_WIDTH, 32, byte-address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, no other clock domains
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted on clk edge when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse
- rsp_error  out  1  misaligned or illegal funct3; valid with rsp_valid
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- mem_wren  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2],2'b00}
- mem_byte_en  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  raw memory word

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. req_ready = (state == IDLE).
- IDLE, accept, legal access: latch write, funct3, addr[1:0], wdata. Go to ISSUE.
- IDLE, accept, illegal access: go directly to RESP with error. No memory access.
- Illegal accesses:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]≠0
  - load funct3 ∈ {011,110,111}
  - store funct3 > 010
- ISSUE: drive mem_address and mem_byte_en.
  - Store: mem_wren=1 for this cycle only, then RESP.
  - Load: go to WAIT with the latency counter loaded to MEM_LATENCY-1.
- WAIT: decrement the counter. At 0, capture the extended mem_rdata into rsp_rdata and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Byte enables:
  - SB/LB/LBU: 4'b0001 << addr[1:0]
  - SH/LH/LHU: 4'b0011 << {addr[1],1'b0}
  - SW/LW: 4'b1111
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extension: select the byte/halfword by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- req_valid while busy is ignored. Request inputs are sampled only on the accept edge.
- rsp_rdata/rsp_error hold their last value until the next response.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, mem_wren=0, mem_address=0, mem_byte_en=0, mem_wdata=0. All memory outputs are registered.
- Accept at edge E:
  - Store: mem_wren high in cycle E+1; rsp_valid in cycle E+2.
  - Load: address presented in cycle E+1; rsp_valid in cycle E+2+MEM_LATENCY.
  - Error: rsp_valid in cycle E+1.
- req_ready returns high the cycle after rsp_valid. Back-to-back accept is possible on that edge.
- mem_byte_en is 0 outside ISSUE/WAIT.
- Reset asserted mid-operation:
  - immediately forces reset values, including dropping mem_wren
  - the in-flight request is discarded, with no rsp_valid
- MEM_LATENCY=1 passes through WAIT for exactly one cycle.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_t
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - alignment-check function
- Sub-module load_extender: combinational lane select plus sign/zero extension. Inputs funct3, addr[1:0] and raw word; output 32-bit result.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF -> cycle E+1: mem_wren=1, mem_address=0x100, mem_byte_en=1111, mem_wdata=0xDEADBEEF; rsp_valid at E+2, rsp_error=0.
- SB addr 0x103, wdata 0x000000A5 -> mem_byte_en=1000, mem_wdata=0xA5A5A5A5.
- mem_rdata=0x80FF7F01 at addr 0x200 (MEM_LATENCY=1), expected rsp_rdata by access:
  - LB offset 3 -> 0xFFFFFF80
  - LBU offset 3 -> 0x00000080
  - LH offset 2 -> 0xFFFF80FF
  - LHU offset 0 -> 0x00007F01
  - LW -> 0x80FF7F01
  - rsp_valid at E+3.
- LW addr 0x102 and SH addr 0x101 -> rsp_valid at E+1 with rsp_error=1, rsp_rdata=0; mem_wren never asserted.
- MEM_LATENCY=3, LW accepted with req_valid held high -> rsp_valid exactly at E+5; no second accept before req_ready returns.
- reset low during WAIT of a load -> all outputs at reset values within the same cycle; no rsp_valid after release; next request completes normally.
